// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side request/response bundle for the memory-stage SRAM controller.
// Master = EXE/MEM side driving requests; slave = the controller returning data/ready.
// Pure wiring, no storage.
interface mem_sram_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: splits a 32-bit load/store into two halfword phases on a 16-bit async SRAM.
// Latency: request in cycle 0 -> ready in cycle 1 + 2*WAIT_CYC; back-to-back costs 2 + 2*WAIT_CYC.
// Backpressure: ready stays low for the whole access so the pipeline freezes; inputs are latched in IDLE.
module mem_sram_ctrl #(
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYC  = 2,
  parameter int SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  mem_sram_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [15:0]        io_sram_dq,
  output logic               o_sram_we_n
);

  localparam int            CW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic               r_is_wr;
  logic [15:0]        r_rdata_lo;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_sram_addr;

  logic               w_req;
  logic               w_last;
  logic               w_drive;
  logic [31:0]        w_off;
  logic [SRAM_AW-2:0] w_word;
  logic [15:0]        w_dq_out;
  logic               w_unused_off;

  assign w_req  = bus.mem_r_en | bus.mem_w_en;
  // Byte offset from the SRAM window; low two bits ignored, upper bits truncated to the SRAM word range.
  assign w_off  = bus.addr - 32'(BASE_ADDR);
  assign w_word = w_off[SRAM_AW:2];
  assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};

  assign w_last   = (r_cnt == '0);
  // The bus is only ever driven during the two data phases of a write.
  assign w_drive  = r_is_wr & ((r_state == S_LOW) | (r_state == S_HIGH));
  assign w_dq_out = (r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0];

  assign io_sram_dq  = w_drive ? w_dq_out : 16'hzzzz;
  assign o_sram_we_n = ~w_drive;
  assign o_sram_addr = r_sram_addr;
  assign bus.rdata   = r_rdata;
  // Ready is high in DONE, in IDLE without a request, and while reset is held.
  assign bus.ready   = rst | (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req);

  // Access sequencer: latch request in IDLE, step through low/high halfword phases, then one DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_rdata_lo  <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_word      <= w_word;
            r_wdata     <= bus.wdata;
            r_is_wr     <= bus.mem_w_en;
            r_cnt       <= CNT_LOAD;
            r_sram_addr <= {w_word, 1'b0};
            r_state     <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_last) begin
            if (!r_is_wr) r_rdata_lo <= io_sram_dq;
            r_cnt       <= CNT_LOAD;
            r_sram_addr <= {r_word, 1'b1};
            r_state     <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_HIGH: begin
          if (w_last) begin
            if (!r_is_wr) r_rdata <= {io_sram_dq, r_rdata_lo};
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: behavioural SRAM models, scoreboard queue for load data,
// immediate-assertion checks with one summary line at the end.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic mem_init;

  mem_sram_ctrl_if ifa ();
  mem_sram_ctrl_if ifb ();

  wire [17:0] a_addr;
  wire [17:0] b_addr;
  wire [15:0] a_dq;
  wire [15:0] b_dq;
  wire        a_we_n;
  wire        b_we_n;

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYC(2), .SRAM_AW(18)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .o_sram_addr(a_addr), .io_sram_dq(a_dq), .o_sram_we_n(a_we_n)
  );

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYC(1), .SRAM_AW(18)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .o_sram_addr(b_addr), .io_sram_dq(b_dq), .o_sram_we_n(b_we_n)
  );

  // Initial SRAM contents pattern
  function automatic logic [15:0] pat(input int i);
    return 16'(i * 291 + 1234);
  endfunction

  // Async SRAM models: drive data whenever not writing, store on clock while we_n is low
  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];
  assign a_dq = a_we_n ? mem_a[a_addr] : 16'hzzzz;
  assign b_dq = b_we_n ? mem_b[b_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] <= pat(i);
        mem_b[i] <= pat(i);
      end
    end else begin
      if (!a_we_n) mem_a[a_addr] <= a_dq;
      if (!b_we_n) mem_b[b_addr] <= b_dq;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q [$];
  logic [31:0] got;
  logic [31:0] exp1;
  logic [31:0] exp2;
  int          cyc;
  logic [17:0] lo_a;
  logic [17:0] hi_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single load on instance A; inputs are scrambled after cycle 0 to prove they are latched
  task automatic issue_read_a(input logic [31:0] addr, input logic [31:0] exp,
                              output int c_done, output logic [17:0] lo, output logic [17:0] hi);
    logic [31:0] e;
    ifa.mem_r_en = 1'b1;
    ifa.addr     = addr;
    sb_q.push_back(exp);
    #1;
    check("rd_c0_ready", 32'(ifa.ready), 32'd0);
    c_done = -1;
    lo     = '0;
    hi     = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        ifa.mem_r_en = 1'b0;
        ifa.addr     = 32'hFFFF_FFF0;
        #1;
        lo = a_addr;
        check("rd_we_n", 32'(a_we_n), 32'd1);
      end
      if (k == 3) hi = a_addr;
      if (ifa.ready) begin
        c_done = k;
        break;
      end
    end
    check("rd_lat", 32'(c_done), 32'd5);
    e = sb_q.pop_front();
    check("rd_data", ifa.rdata, e);
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    mem_init = 1'b1;
    ifa.mem_r_en = 1'b0; ifa.mem_w_en = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.mem_r_en = 1'b0; ifb.mem_w_en = 1'b0; ifb.addr = '0; ifb.wdata = '0;
    #1;
    // Reset state
    check("rst_ready",  32'(ifa.ready), 32'd1);
    check("rst_rdata",  ifa.rdata, 32'd0);
    check("rst_we_n",   32'(a_we_n), 32'd1);
    check("rst_addr",   32'(a_addr), 32'd0);
    check("rst_b_ready", 32'(ifb.ready), 32'd1);
    check("rst_b_rdata", ifb.rdata, 32'd0);
    tick();
    tick();
    mem_init = 1'b0;
    rst      = 1'b0;
    tick();
    check("idle_ready", 32'(ifa.ready), 32'd1);

    // Store 0xDEADBEEF to byte 1024
    ifa.mem_w_en = 1'b1;
    ifa.addr     = 32'd1024;
    ifa.wdata    = 32'hDEAD_BEEF;
    #1;
    check("st_c0_ready", 32'(ifa.ready), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        ifa.mem_w_en = 1'b0;
        ifa.addr     = 32'h0000_0BAD;
        ifa.wdata    = 32'h0;
        #1;
      end
      if (c < 5) begin
        check("st_addr",  32'(a_addr), (c < 3) ? 32'd0 : 32'd1);
        check("st_dq",    32'(a_dq), (c < 3) ? 32'hBEEF : 32'hDEAD);
        check("st_we_n",  32'(a_we_n), 32'd0);
        check("st_ready", 32'(ifa.ready), 32'd0);
      end else begin
        check("st_done_ready", 32'(ifa.ready), 32'd1);
        check("st_done_we_n",  32'(a_we_n), 32'd1);
      end
    end
    tick();
    check("st_mem_lo", 32'(mem_a[0]), 32'hBEEF);
    check("st_mem_hi", 32'(mem_a[1]), 32'hDEAD);

    // Load back the stored word
    issue_read_a(32'd1024, 32'hDEAD_BEEF, cyc, lo_a, hi_a);
    check("ld_lo_addr", 32'(lo_a), 32'd0);
    check("ld_hi_addr", 32'(hi_a), 32'd1);

    // Address mapping: word 100 -> halfwords 200/201
    issue_read_a(32'd1024 + 32'd400, {pat(201), pat(200)}, cyc, lo_a, hi_a);
    check("map_lo_addr", 32'(lo_a), 32'd200);
    check("map_hi_addr", 32'(hi_a), 32'd201);

    // Back-to-back loads with the request held; upstream advances address after DONE
    exp1 = {pat(3), pat(2)};
    exp2 = {pat(5), pat(4)};
    sb_q.push_back(exp1);
    sb_q.push_back(exp2);
    ifa.mem_r_en = 1'b1;
    ifa.addr     = 32'd1028;
    #1;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) begin
        tick();
        if (c == 6) begin
          ifa.addr = 32'd1032;
          #1;
        end
      end
      check("b2b_ready", 32'(ifa.ready), (c == 5 || c == 11) ? 32'd1 : 32'd0);
      if (c == 5 || c == 11) begin
        got = sb_q.pop_front();
        check("b2b_data", ifa.rdata, got);
      end else if (c > 5) begin
        check("b2b_hold", ifa.rdata, exp1);
      end
    end
    ifa.mem_r_en = 1'b0;
    tick();
    check("b2b_idle_ready", 32'(ifa.ready), 32'd1);
    check("b2b_idle_rdata", ifa.rdata, exp2);

    // Simultaneous read+write is a write; rdata must not move
    ifa.mem_r_en = 1'b1;
    ifa.mem_w_en = 1'b1;
    ifa.addr     = 32'd1036;
    ifa.wdata    = 32'h1234_5678;
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        ifa.mem_r_en = 1'b0;
        ifa.mem_w_en = 1'b0;
        #1;
        check("rw_we_n_lo", 32'(a_we_n), 32'd0);
        check("rw_dq_lo",   32'(a_dq), 32'h5678);
        check("rw_addr_lo", 32'(a_addr), 32'd6);
      end
      if (c == 3) begin
        check("rw_we_n_hi", 32'(a_we_n), 32'd0);
        check("rw_dq_hi",   32'(a_dq), 32'h1234);
        check("rw_addr_hi", 32'(a_addr), 32'd7);
      end
      if (c == 5) begin
        check("rw_done_ready", 32'(ifa.ready), 32'd1);
        check("rw_rdata_hold", ifa.rdata, exp2);
      end
    end
    tick();
    issue_read_a(32'd1036, 32'h1234_5678, cyc, lo_a, hi_a);

    // Reset in the middle of the high phase of a write
    ifa.mem_w_en = 1'b1;
    ifa.addr     = 32'd1040;
    ifa.wdata    = 32'hCAFE_F00D;
    #1;
    tick();
    ifa.mem_w_en = 1'b0;
    tick();
    tick();
    check("mid_we_n", 32'(a_we_n), 32'd0);
    check("mid_dq",   32'(a_dq), 32'hCAFE);
    rst = 1'b1;
    #1;
    check("arst_we_n",  32'(a_we_n), 32'd1);
    check("arst_ready", 32'(ifa.ready), 32'd1);
    check("arst_rdata", ifa.rdata, 32'd0);
    check("arst_addr",  32'(a_addr), 32'd0);
    check("arst_dq_released", 32'(a_dq), 32'hBEEF);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(ifa.ready), 32'd1);
    check("post_rst_we_n",  32'(a_we_n), 32'd1);

    // WAIT_CYC = 1 instance: word 5 -> halfwords 10/11, done in cycle 3
    ifb.mem_r_en = 1'b1;
    ifb.addr     = 32'd1044;
    sb_q.push_back({pat(11), pat(10)});
    #1;
    check("w1_c0_ready", 32'(ifb.ready), 32'd0);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        ifb.mem_r_en = 1'b0;
        ifb.addr     = 32'h0;
        #1;
        check("w1_lo_addr", 32'(b_addr), 32'd10);
      end
      if (k == 2) check("w1_hi_addr", 32'(b_addr), 32'd11);
      if (ifb.ready) begin
        cyc = k;
        break;
      end
    end
    check("w1_lat", 32'(cyc), 32'd3);
    got = sb_q.pop_front();
    check("w1_data", ifb.rdata, got);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
